// File: rtl/shift_lsh16_seq.sv
// Sequential 16-bit left-shift engine: logical, rotate and ones-fill modes,
// one bit position per clock, with sticky overflow for set bits lost off the MSB.
module shift_lsh16_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] din,
   input  logic [3:0]  shamt,
   input  logic [1:0]  mode,
   output logic        busy,
   output logic        done,
   output logic [15:0] dout,
   output logic        ovf
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] r_q, r_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [1:0]  m_q, m_d;
   logic        ovf_q, ovf_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        fill;

   // Mode 11 falls into the default arm and behaves as logical left
   always_comb begin
      case (m_q)
         2'b01:   fill = r_q[15];
         2'b10:   fill = 1'b1;
         default: fill = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      m_d     = m_q;
      ovf_d   = ovf_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               r_d     = din;
               cnt_d   = shamt;
               m_d     = mode;
               ovf_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_q != 4'd0) begin
               r_d   = {r_q[14:0], fill};
               ovf_d = ovf_q | (r_q[15] & (m_q != 2'b01));
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         r_q     <= 16'h0000;
         cnt_q   <= 4'd0;
         m_q     <= 2'b00;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         m_q     <= m_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign dout = r_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_shift_lsh16_seq.sv
// Scoreboard bench for shift_lsh16_seq: driver pushes expected results from an
// arithmetic reference model, a negedge monitor pops them on done.
module tb_shift_lsh16_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] din = 16'h0000;
   logic [3:0]  shamt = 4'd0;
   logic [1:0]  mode = 2'b00;
   logic        busy, done, ovf;
   logic [15:0] dout;

   always #5 clk = ~clk;

   shift_lsh16_seq dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .din   (din),
      .shamt (shamt),
      .mode  (mode),
      .busy  (busy),
      .done  (done),
      .dout  (dout),
      .ovf   (ovf)
   );

   typedef struct {
      int          acc_edge;
      int          done_edge;
      logic [15:0] res;
      logic        ovf;
   } exp_t;

   exp_t        exp_q[$];
   int          edge_cnt = 0;
   int          next_free = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] hold_dout = 16'h0000;
   logic        hold_ovf = 1'b0;
   bit          mon_en = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0h, required %0h (edge %0d)", name, act, req, edge_cnt);
      end
   endtask

   // Shift as plain arithmetic on a 32-bit word: the upper half holds what left bit 15
   function automatic void refModel(input logic [15:0] d, input logic [3:0] sh,
                                    input logic [1:0] md, output logic [15:0] r, output logic o);
      logic [31:0] wide;
      logic [15:0] ones;
      wide = {16'h0000, d} << sh;
      ones = ~(16'hFFFF << sh);
      case (md)
         2'b01: begin r = wide[15:0] | wide[31:16]; o = 1'b0; end
         2'b10: begin r = wide[15:0] | ones;        o = |wide[31:16]; end
         default: begin r = wide[15:0];             o = |wide[31:16]; end
      endcase
   endfunction

   always @(posedge clk) begin
      edge_cnt++;
      if (rst) begin
         exp_q.delete();
         next_free = edge_cnt + 1;
         hold_dout = 16'h0000;
         hold_ovf  = 1'b0;
      end
   end

   // An op started before edge E is accepted when the engine is idle at E;
   // it finishes shamt+1 edges later and the next accept can happen one edge after that
   task automatic applyStimulus(input bit s, input logic [15:0] d, input logic [3:0] sh,
                                input logic [1:0] md, output bit acc);
      logic [15:0] r;
      logic        o;
      @(negedge clk);
      rst   = 1'b0;
      start = s;
      din   = d;
      shamt = sh;
      mode  = md;
      acc   = 1'b0;
      if (s && (edge_cnt + 1 >= next_free)) begin
         refModel(d, sh, md, r, o);
         exp_q.push_back('{edge_cnt + 1, edge_cnt + int'(sh) + 2, r, o});
         next_free = edge_cnt + int'(sh) + 3;
         acc = 1'b1;
      end
   endtask

   task automatic runOp(input logic [15:0] d, input logic [3:0] sh, input logic [1:0] md);
      bit a;
      int tries;
      a = 1'b0;
      tries = 0;
      while (!a && tries < 40) begin
         applyStimulus(1'b1, d, sh, md, a);
         tries++;
      end
      if (!a) checkOutput("accept_bound", 32'd0, 32'd1);
   endtask

   task automatic idleCycles(input int n);
      bit a;
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0000, 4'd0, 2'b00, a);
   endtask

   task automatic waitIdle();
      int guard;
      guard = 0;
      while ((edge_cnt + 1 < next_free) && guard < 40) begin
         idleCycles(1);
         guard++;
      end
   endtask

   task automatic applyReset();
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b0;
      @(negedge clk);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_done", done, 1'b0);
      checkOutput("rst_dout", dout, 16'h0000);
      checkOutput("rst_ovf",  ovf,  1'b0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      bit   exp_busy;
      if (mon_en) begin
         if (!done && exp_q.size() > 0 && exp_q[0].done_edge <= edge_cnt) begin
            checkOutput("missing_done", 32'd0, 32'd1);
            void'(exp_q.pop_front());
         end
         exp_busy = (exp_q.size() > 0) && (exp_q[0].acc_edge <= edge_cnt) &&
                    (edge_cnt < exp_q[0].done_edge);
         checkOutput("busy", busy, exp_busy);
         if (done) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               checkOutput("done_edge", edge_cnt, e.done_edge);
               checkOutput("dout", dout, e.res);
               checkOutput("ovf",  ovf,  e.ovf);
               hold_dout = e.res;
               hold_ovf  = e.ovf;
            end
         end else if (!exp_busy) begin
            checkOutput("dout_hold", dout, hold_dout);
            checkOutput("ovf_hold",  ovf,  hold_ovf);
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, required completion");
      $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit a;
      repeat (2) @(posedge clk);
      mon_en = 1'b1;

      runOp(16'h8001, 4'd4, 2'b00);
      waitIdle();
      idleCycles(1);

      runOp(16'h1234, 4'd4, 2'b01);
      runOp(16'h8000, 4'd15, 2'b01);
      waitIdle();

      runOp(16'h0000, 4'd15, 2'b10);
      waitIdle();
      runOp(16'hFFFF, 4'd1, 2'b10);
      waitIdle();

      runOp(16'hA5A5, 4'd0, 2'b11);
      waitIdle();
      idleCycles(2);

      runOp(16'h0F0F, 4'd6, 2'b00);
      applyStimulus(1'b1, 16'hFFFF, 4'd1, 2'b01, a);
      applyStimulus(1'b0, 16'h0000, 4'd0, 2'b00, a);
      applyStimulus(1'b1, 16'h1234, 4'd2, 2'b10, a);
      waitIdle();
      idleCycles(1);

      runOp(16'hC003, 4'd3, 2'b00);
      runOp(16'h3C3C, 4'd5, 2'b01);
      runOp(16'h8421, 4'd2, 2'b10);
      waitIdle();
      idleCycles(1);

      runOp(16'hFFFF, 4'd10, 2'b00);
      idleCycles(2);
      applyReset();
      idleCycles(12);
      runOp(16'h1357, 4'd3, 2'b00);
      waitIdle();
      idleCycles(2);

      for (int i = 0; i < 40; i++) begin
         runOp(16'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
         for (int g = 0; g < int'($urandom_range(0, 4)); g++)
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom),
                          4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), a);
      end
      waitIdle();
      idleCycles(3);
      checkOutput("queue_drained", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
